// File: rtl/boxcar_decimator_pkg.sv
// ---------------------------------------------------------------------------
// boxcar_decimator_pkg
//   Shared DSP helpers for the boxcar filter chain: a common wide working
//   width, round-half-up arithmetic shift, signed saturation with a clamp
//   flag, and the level encoding used by the 2-entry sample FIFO.
//   No ports (package).
// ---------------------------------------------------------------------------
package boxcar_decimator_pkg;

   // Working width for the shared helpers; wide enough for any stage input
   // plus the rounding carry.
   localparam int DSP_W = 32;

   typedef struct packed {
      logic signed [DSP_W-1:0] value;
      logic                    clamped;
   } sat_result_t;

   // Occupancy of the 2-entry FIFO; the encoding doubles as the count.
   typedef enum logic [1:0] {
      LVL_EMPTY = 2'd0,
      LVL_ONE   = 2'd1,
      LVL_FULL  = 2'd2
   } fifo_level_t;

   // y = (x + 2^(shift-1)) >>> shift, i.e. round half toward +inf.
   function automatic logic signed [DSP_W-1:0] round_shift(
      input logic signed [DSP_W-1:0] x,
      input int unsigned             shift
   );
      logic signed [DSP_W-1:0] bias;
      bias = (shift == 0) ? '0 : (DSP_W'(1) <<< (shift - 1));
      return (x + bias) >>> shift;
   endfunction

   // Clamp y to the signed range of 'width' bits and report whether it moved.
   function automatic sat_result_t saturate(
      input logic signed [DSP_W-1:0] y,
      input int unsigned             width
   );
      logic signed [DSP_W-1:0] hi;
      logic signed [DSP_W-1:0] lo;
      sat_result_t             res;
      hi = (DSP_W'(1) <<< (width - 1)) - DSP_W'(1);
      lo = ~hi;
      res.value   = y;
      res.clamped = 1'b0;
      if (y > hi) begin
         res.value   = hi;
         res.clamped = 1'b1;
      end else if (y < lo) begin
         res.value   = lo;
         res.clamped = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/boxcar_decimator_if.sv
// ---------------------------------------------------------------------------
// boxcar_decimator_if
//   Valid/ready sample stream carrying the decimated output.
//   data  : signed sample (FIFO head)
//   valid : data is valid
//   ready : consumer accepts; transfer when valid && ready
//   master modport drives data/valid, slave modport drives ready.
// ---------------------------------------------------------------------------
interface boxcar_decimator_if #(
   parameter int WIDTH = 8
) ();
   logic signed [WIDTH-1:0] data;
   logic                    valid;
   logic                    ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/boxcar_decimator_sample_fifo2.sv
// ---------------------------------------------------------------------------
// sample_fifo2
//   Two-entry in-order FIFO with first-word-fall-through head.
//   i_clk, i_reset_n : clock, synchronous active-low reset (clears occupancy)
//   push, wr_data    : write request and data (ignored when full w/o pop)
//   pop              : remove head (ignored when empty)
//   rd_data          : head entry, 0 while empty
//   full, empty      : occupancy flags
//   count            : number of entries held (0..2)
// ---------------------------------------------------------------------------
module sample_fifo2
   import boxcar_decimator_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [1:0]       count
);

   fifo_level_t      level, level_nxt;
   logic [WIDTH-1:0] head, tail;
   logic             head_we, head_from_tail, tail_we;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) level <= LVL_EMPTY;
      else            level <= level_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      level_nxt      = level;
      head_we        = 1'b0;
      head_from_tail = 1'b0;
      tail_we        = 1'b0;
      case (level)
         LVL_EMPTY: begin
            if (push) begin
               head_we   = 1'b1;
               level_nxt = LVL_ONE;
            end
         end
         LVL_ONE: begin
            if (push && pop) begin
               head_we = 1'b1;            // old head leaves, new one replaces it
            end else if (push) begin
               tail_we   = 1'b1;
               level_nxt = LVL_FULL;
            end else if (pop) begin
               level_nxt = LVL_EMPTY;
            end
         end
         LVL_FULL: begin
            if (pop) begin
               head_we        = 1'b1;
               head_from_tail = 1'b1;
               if (push) tail_we   = 1'b1;
               else      level_nxt = LVL_ONE;
            end
         end
         default: level_nxt = LVL_EMPTY;
      endcase
   end

   // NOTE: storage has no reset; the read port is gated by 'empty', so stale
   // contents after reset are never visible.
   always_ff @(posedge i_clk) begin
      if (head_we) head <= head_from_tail ? tail : wr_data;
      if (tail_we) tail <= wr_data;
   end

   assign empty   = (level == LVL_EMPTY);
   assign full    = (level == LVL_FULL);
   assign count   = level;
   assign rd_data = empty ? '0 : head;

`ifdef FORMAL
   a_count_le_2: assert property (@(posedge i_clk) count <= 2'd2);
`endif

endmodule

// File: rtl/boxcar_decimator.sv
// ---------------------------------------------------------------------------
// boxcar_decimator
//   Keeps one of every DECIMATION filter samples, rounds/saturates it to
//   OUT_WIDTH and queues it in a 2-entry FIFO toward a valid/ready consumer.
//   i_clk, i_reset_n   : clock, synchronous active-low reset
//   i_ce, i_valid      : sample strobe and qualifier; event = both high
//   i_data             : signed filtered sample
//   dec_out (master)   : data/valid out, ready in (FIFO head)
//   o_saturated        : 1-cycle pulse, last kept sample was clamped
//   o_overflow         : sticky, a kept sample was dropped on a full FIFO
//   i_clear_overflow   : clears o_overflow (a simultaneous drop wins)
// ---------------------------------------------------------------------------
module boxcar_decimator
   import boxcar_decimator_pkg::*;
#(
   parameter int IN_WIDTH   = 9,
   parameter int OUT_WIDTH  = 8,
   parameter int DECIMATION = 4,
   parameter int SHIFT      = 1
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic                       i_ce,
   input  logic                       i_valid,
   input  logic signed [IN_WIDTH-1:0] i_data,
   boxcar_decimator_if.master         dec_out,
   output logic                       o_saturated,
   output logic                       o_overflow,
   input  logic                       i_clear_overflow
);

   localparam int PHASE_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

   logic               in_event, keep, pop, drop, fifo_push;
   logic               fifo_full, fifo_empty;
   logic [1:0]         fifo_count_unused;
   logic [PHASE_W-1:0] phase;
   logic signed [DSP_W-1:0] x_ext, y_round;
   sat_result_t        y_sat;
   logic               sat_hi_unused;

   assign in_event = i_ce && i_valid;
   assign keep     = in_event && (phase == '0);

   generate
      if (DECIMATION == 1) begin : g_no_phase
         assign phase = '0;
      end else begin : g_phase
         always_ff @(posedge i_clk) begin
            if (!i_reset_n) begin
               phase <= '0;
            end else if (in_event) begin
               phase <= (phase == PHASE_W'(DECIMATION - 1)) ? '0 : phase + 1'b1;
            end
         end
      end
   endgenerate

   // Round then clamp in the wide working width; only the low OUT_WIDTH bits
   // of an in-range result are meaningful.
   always_comb begin
      x_ext   = DSP_W'(i_data);
      y_round = round_shift(x_ext, SHIFT);
      y_sat   = saturate(y_round, OUT_WIDTH);
   end
   assign sat_hi_unused = ^y_sat.value[DSP_W-1:OUT_WIDTH];

   assign pop       = dec_out.valid && dec_out.ready;
   assign drop      = keep && fifo_full && !pop;
   assign fifo_push = keep && !drop;

   sample_fifo2 #(.WIDTH(OUT_WIDTH)) u_fifo (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .push      (fifo_push),
      .pop       (pop),
      .wr_data   (y_sat.value[OUT_WIDTH-1:0]),
      .rd_data   (dec_out.data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count_unused)
   );

   assign dec_out.valid = !fifo_empty;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         o_saturated <= 1'b0;
         o_overflow  <= 1'b0;
      end else begin
         o_saturated <= keep && y_sat.clamped;
         if (drop)                  o_overflow <= 1'b1;
         else if (i_clear_overflow) o_overflow <= 1'b0;
      end
   end

`ifdef FORMAL
   a_hold_while_stalled: assert property (@(posedge i_clk) disable iff (!i_reset_n)
      dec_out.valid && !dec_out.ready |=> $stable(dec_out.data));
   a_no_push_on_drop: assert property (@(posedge i_clk) drop |-> !fifo_push);
`endif

endmodule

// File: tb/tb_boxcar_decimator.sv
// ---------------------------------------------------------------------------
// tb_boxcar_decimator
//   Directed bench for boxcar_decimator (IN_WIDTH=9, OUT_WIDTH=8,
//   DECIMATION=4, SHIFT=1). Expected values are hand-computed from
//   y = clamp((x + 1) >>> 1, -128, 127).
// ---------------------------------------------------------------------------
module tb_boxcar_decimator;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ce, vin, clr_ov;
   logic signed [8:0] din;
   logic              sat, ovf;

   int n_cmp = 0;
   int n_err = 0;

   boxcar_decimator_if #(.WIDTH(8)) bus ();

   boxcar_decimator #(
      .IN_WIDTH(9), .OUT_WIDTH(8), .DECIMATION(4), .SHIFT(1)
   ) dut (
      .i_clk            (clk),
      .i_reset_n        (rst_n),
      .i_ce             (ce),
      .i_valid          (vin),
      .i_data           (din),
      .dec_out          (bus),
      .o_saturated      (sat),
      .o_overflow       (ovf),
      .i_clear_overflow (clr_ov)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One input event carrying x, then inputs go idle.
   task automatic send(input int x);
      din = 9'(x);
      ce  = 1'b1;
      vin = 1'b1;
      tick();
      ce  = 1'b0;
      vin = 1'b0;
   endtask

   // n non-kept zero-valued events to walk the phase forward.
   task automatic fillers(input int n);
      for (int k = 0; k < n; k++) send(0);
   endtask

   initial begin
      rst_n  = 1'b0;
      ce     = 1'b0;
      vin    = 1'b0;
      clr_ov = 1'b0;
      din    = '0;
      bus.ready = 1'b0;
      tick();
      tick();
      check("rst_valid", 32'(bus.valid), 0);
      check("rst_data",  32'(bus.data),  0);
      check("rst_sat",   32'(sat),       0);
      check("rst_ovf",   32'(ovf),       0);
      rst_n = 1'b1;

      // 1. continuous events, x = 0..11, outputs 0,2,4 one cycle after 0,4,8
      bus.ready = 1'b1;
      for (int x = 0; x < 12; x++) begin
         send(x);
         check($sformatf("t1_valid_x%0d", x), 32'(bus.valid), (x % 4 == 0) ? 1 : 0);
         if (x % 4 == 0) check($sformatf("t1_data_x%0d", x), 32'(bus.data), (x + 1) / 2);
      end

      // 2. rounding and saturation
      send(3);    check("t2_data_3", 32'(bus.data), 2);
                  check("t2_sat_3",  32'(sat), 0);
      fillers(3);
      send(-3);   check("t2_data_m3", 32'(bus.data), -1);
                  check("t2_sat_m3",  32'(sat), 0);
      fillers(3);
      send(255);  check("t2_data_255", 32'(bus.data), 127);
                  check("t2_sat_255",  32'(sat), 1);
      fillers(1); check("t2_sat_pulse_end", 32'(sat), 0);
      fillers(2);
      send(-256); check("t2_data_m256", 32'(bus.data), -128);
                  check("t2_sat_m256",  32'(sat), 0);
      fillers(3);

      // 3. stall: 10, 20 queued, 30 dropped
      bus.ready = 1'b0;
      send(10);   check("t3_data_a", 32'(bus.data), 5);
      fillers(3);
      send(20);   check("t3_data_held", 32'(bus.data), 5);
                  check("t3_ovf_before", 32'(ovf), 0);
      fillers(3);
      send(30);   check("t3_ovf_set", 32'(ovf), 1);
                  check("t3_data_after_drop", 32'(bus.data), 5);
      fillers(3); check("t3_ovf_sticky", 32'(ovf), 1);
      bus.ready = 1'b1;
      tick();     check("t3_second", 32'(bus.data), 10);
                  check("t3_second_valid", 32'(bus.valid), 1);
      tick();     check("t3_drained", 32'(bus.valid), 0);
                  check("t3_ovf_still", 32'(ovf), 1);
      clr_ov = 1'b1;
      tick();
      clr_ov = 1'b0;
      check("t3_ovf_cleared", 32'(ovf), 0);

      // 4. full FIFO, push and pop together
      bus.ready = 1'b0;
      send(40);   check("t4_head_a", 32'(bus.data), 20);
      fillers(3);
      send(50);   check("t4_head_full", 32'(bus.data), 20);
      fillers(3);
      bus.ready = 1'b1;
      send(60);
      bus.ready = 1'b0;
      check("t4_head_b", 32'(bus.data), 25);
      check("t4_no_ovf", 32'(ovf), 0);
      fillers(3); check("t4_head_b_held", 32'(bus.data), 25);
      bus.ready = 1'b1;
      tick();     check("t4_head_c", 32'(bus.data), 30);
                  check("t4_valid_c", 32'(bus.valid), 1);
      tick();     check("t4_drained", 32'(bus.valid), 0);

      // count=1, push and pop together: new sample becomes head
      bus.ready = 1'b0;
      send(70);   check("t4b_head", 32'(bus.data), 35);
      fillers(3);
      bus.ready = 1'b1;
      send(80);   check("t4b_replaced", 32'(bus.data), 40);
                  check("t4b_valid", 32'(bus.valid), 1);
      fillers(1); check("t4b_single", 32'(bus.valid), 0);
      fillers(2);

      // 5. i_valid alternating with i_ce=1: keep interval of 8 cycles
      for (int i = 0; i < 16; i++) begin
         ce  = 1'b1;
         vin = (i % 2 == 0);
         din = 9'(i + 1);
         tick();
         check($sformatf("t5_valid_c%0d", i), 32'(bus.valid), (i == 0 || i == 8) ? 1 : 0);
         if (i == 0) check("t5_data_c0", 32'(bus.data), 1);
         if (i == 8) check("t5_data_c8", 32'(bus.data), 5);
      end
      ce  = 1'b0;
      vin = 1'b1;
      din = 9'sd50;
      tick(); tick(); tick();
      check("t5_valid_only_ignored", 32'(bus.valid), 0);
      send(11);   check("t5_next_kept", 32'(bus.data), 6);
                  check("t5_next_valid", 32'(bus.valid), 1);
      fillers(3);

      // 6. reset with FIFO full, overflow set, phase=2
      bus.ready = 1'b0;
      send(100);
      fillers(3);
      send(102);
      fillers(3);
      send(104);  check("t6_ovf_pre", 32'(ovf), 1);
                  check("t6_head_pre", 32'(bus.data), 50);
      fillers(1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t6_valid", 32'(bus.valid), 0);
      check("t6_ovf",   32'(ovf), 0);
      check("t6_data",  32'(bus.data), 0);
      send(20);   check("t6_kept_valid", 32'(bus.valid), 1);
                  check("t6_kept_data",  32'(bus.data), 10);
      bus.ready = 1'b1;
      tick();     check("t6_drained", 32'(bus.valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
